wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback stage and architectural register file for the five-stage pipeline; it consumes the MEM/WB pipeline register outputs. Each cycle it selects the writeback value (memory data or ALU result), commits it to a 32x32-bit register file and serves two combinational read ports to ID with same-cycle write bypass. It also holds the last committed write for EX-stage forwarding, and a retired-write counter.

## Interface
Parameters:
- BYPASS, 1: 1 = read ports return the in-flight writeback value on address match; 0 = read ports show stored contents only.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- RegWrite_i  input  1  write enable, from MEM/WB RegWrite_o.
- MemtoReg_i  input  1  1 = write Data_i, 0 = write ALUout_i.
- Data_i  input  32  load data from MEM/WB.
- ALUout_i  input  32  ALU result from MEM/WB.
- RDaddr_i  input  5  destination register.
- RSaddr_i  input  5  read port A address.
- RTaddr_i  input  5  read port B address.
- RSdata_o  output  32  read port A data.
- RTdata_o  output  32  read port B data.
- WBdata_o  output  32  combinational writeback value (MemtoReg_i ? Data_i : ALUout_i).
- WBvalid_o  output  1  combinational; RegWrite_i & (RDaddr_i != 0) & ~rst_i.
- LastAddr_o  output  5  registered address of the last committed write.
- LastData_o  output  32  registered data of the last committed write.
- LastValid_o  output  1  registered; 1 for exactly one cycle after a committed write.
- WBcount_o  output  32  number of committed writes since reset.

## Operation
- Effective write: WBvalid_o = 1. On the rising edge, reg[RDaddr_i] <= WBdata_o.
- Register 0 is hardwired to 0. A write to address 0 is dropped: no state change, no count, LastValid_o = 0 next cycle.
- Read port A, combinational (port B identical with RTaddr_i):
  - RSaddr_i == 0 -> 0.
  - BYPASS = 1 and WBvalid_o = 1 and RSaddr_i == RDaddr_i -> WBdata_o.
  - Otherwise -> reg[RSaddr_i].
- Both ports may read the same address. Both may hit the bypass in the same cycle.
- LastAddr_o / LastData_o:
  - Load RDaddr_i / WBdata_o on every effective write.
  - Hold their values otherwise.
- LastValid_o <= WBvalid_o every cycle.
- WBcount_o:
  - Increments by 1 on each effective write.
  - Wraps modulo 2^32: 0xFFFFFFFF -> 0x00000000.
- MemtoReg_i is ignored for storage when RegWrite_i = 0. WBdata_o still reflects the mux.
- No state machine. State is the 31 data registers, the Last* registers and the counter.

## Timing
- Write latency: a value committed at edge N is visible from storage after edge N.
- With BYPASS = 1, the value is visible on the read ports in the same cycle as the write, before edge N.
- Read ports: zero-latency combinational paths from addresses, inputs and storage.
- Reset, asynchronous:
  - rst_i rising immediately clears all registers, LastAddr_o = 0, LastData_o = 0, LastValid_o = 0 and WBcount_o = 0.
  - While rst_i is high: WBvalid_o = 0, no write or count occurs, read ports return 0, and WBdata_o still shows the mux result.
- Reset deasserted mid-cycle: the first edge with rst_i low may commit a write.
- Write and read of the same register in one cycle, BYPASS = 0: the read returns the old value, and the new value appears after the edge.
- Back-to-back writes to the same register: the last one wins. LastValid_o stays 1 across consecutive committed writes.

## Test plan
- Reset, then read all 32 addresses on both ports -> all 0. WBcount_o = 0, LastValid_o = 0.
- Write each of the 31 nonzero registers with RegWrite_i = 1, MemtoReg_i = 0, ALUout_i = 0xA5000000 + addr, then read them back with no write active -> each port returns 0xA5000000 + addr. WBcount_o = 31.
- Same-cycle bypass: RDaddr_i = 7, MemtoReg_i = 1, Data_i = 0xDEADBEEF, RSaddr_i = RTaddr_i = 7 -> both ports 0xDEADBEEF in that cycle with BYPASS = 1. With BYPASS = 0 they show the prior value, then 0xDEADBEEF next cycle. Next cycle LastAddr_o = 7, LastData_o = 0xDEADBEEF, LastValid_o = 1.
- Write to address 0 with ALUout_i = 0x12345678 -> reg 0 still reads 0, WBvalid_o = 0, WBcount_o unchanged, LastValid_o = 0 next cycle.
- Force WBcount_o near wrap (0xFFFFFFFE via 2 writes from a preloaded test hook or long run) -> after 2 more effective writes it reads 0x00000000.
- Assert rst_i asynchronously between edges after registers hold data -> outputs and storage read 0 immediately, with no clock edge needed. A write presented during reset is not committed.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback stage and 32x32 architectural register file: writeback mux, two
// combinational read ports with optional same-cycle bypass, last-write
// forwarding registers and a retired-write counter.
module wb_regfile #(
   parameter bit          BYPASS     = 1'b1,
   // Counter value loaded on reset; nonzero only to reach the wrap point quickly.
   parameter logic [31:0] COUNT_INIT = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        RegWrite_i,
   input  logic        MemtoReg_i,
   input  logic [31:0] Data_i,
   input  logic [31:0] ALUout_i,
   input  logic [4:0]  RDaddr_i,
   input  logic [4:0]  RSaddr_i,
   input  logic [4:0]  RTaddr_i,
   output logic [31:0] RSdata_o,
   output logic [31:0] RTdata_o,
   output logic [31:0] WBdata_o,
   output logic        WBvalid_o,
   output logic [4:0]  LastAddr_o,
   output logic [31:0] LastData_o,
   output logic        LastValid_o,
   output logic [31:0] WBcount_o
);

   logic [31:0] regs [0:31];
   logic [31:0] wb_data;
   logic        wb_valid;
   logic [4:0]  last_addr;
   logic [31:0] last_data;
   logic        last_valid;
   logic [31:0] wb_count;

   assign wb_data  = MemtoReg_i ? Data_i : ALUout_i;
   assign wb_valid = RegWrite_i & (RDaddr_i != 5'd0) & ~rst_i;

   // Entry 0 is cleared on reset and never written, so it always reads zero.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= 32'h0;
         end
         last_addr  <= 5'd0;
         last_data  <= 32'h0;
         last_valid <= 1'b0;
         wb_count   <= COUNT_INIT;
      end else begin
         last_valid <= wb_valid;
         if (wb_valid) begin
            regs[RDaddr_i] <= wb_data;
            last_addr      <= RDaddr_i;
            last_data      <= wb_data;
            wb_count       <= wb_count + 32'd1;
         end
      end
   end

   always_comb begin
      RSdata_o = 32'h0;
      if (rst_i || RSaddr_i == 5'd0) begin
         RSdata_o = 32'h0;
      end else if (BYPASS && wb_valid && RSaddr_i == RDaddr_i) begin
         RSdata_o = wb_data;
      end else begin
         RSdata_o = regs[RSaddr_i];
      end
   end

   always_comb begin
      RTdata_o = 32'h0;
      if (rst_i || RTaddr_i == 5'd0) begin
         RTdata_o = 32'h0;
      end else if (BYPASS && wb_valid && RTaddr_i == RDaddr_i) begin
         RTdata_o = wb_data;
      end else begin
         RTdata_o = regs[RTaddr_i];
      end
   end

   assign WBdata_o    = wb_data;
   assign WBvalid_o   = wb_valid;
   assign LastAddr_o  = last_addr;
   assign LastData_o  = last_data;
   assign LastValid_o = last_valid;
   assign WBcount_o   = wb_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a bypassing instance and a non-bypassing
// instance whose counter starts two writes short of wraparound share all inputs.
module tb_wb_regfile;

   logic        clk;
   logic        rst;
   logic        reg_write;
   logic        mem_to_reg;
   logic [31:0] data;
   logic [31:0] alu_out;
   logic [4:0]  rd_addr;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;

   logic [31:0] rs_data, rt_data, wb_data, last_data, wb_count;
   logic        wb_valid, last_valid;
   logic [4:0]  last_addr;

   logic [31:0] nb_rs_data, nb_rt_data, nb_wb_data, nb_last_data, nb_wb_count;
   logic        nb_wb_valid, nb_last_valid;
   logic [4:0]  nb_last_addr;

   int checks = 0;
   int passed = 0;

   wb_regfile #(.BYPASS(1'b1)) dut (
      .clk_i(clk), .rst_i(rst), .RegWrite_i(reg_write), .MemtoReg_i(mem_to_reg),
      .Data_i(data), .ALUout_i(alu_out), .RDaddr_i(rd_addr), .RSaddr_i(rs_addr),
      .RTaddr_i(rt_addr), .RSdata_o(rs_data), .RTdata_o(rt_data), .WBdata_o(wb_data),
      .WBvalid_o(wb_valid), .LastAddr_o(last_addr), .LastData_o(last_data),
      .LastValid_o(last_valid), .WBcount_o(wb_count)
   );

   wb_regfile #(.BYPASS(1'b0), .COUNT_INIT(32'hFFFF_FFFE)) dut_nb (
      .clk_i(clk), .rst_i(rst), .RegWrite_i(reg_write), .MemtoReg_i(mem_to_reg),
      .Data_i(data), .ALUout_i(alu_out), .RDaddr_i(rd_addr), .RSaddr_i(rs_addr),
      .RTaddr_i(rt_addr), .RSdata_o(nb_rs_data), .RTdata_o(nb_rt_data), .WBdata_o(nb_wb_data),
      .WBvalid_o(nb_wb_valid), .LastAddr_o(nb_last_addr), .LastData_o(nb_last_data),
      .LastValid_o(nb_last_valid), .WBcount_o(nb_wb_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Present a full input vector on the falling edge; combinational outputs settle by #1.
   task automatic drive(input logic we, input logic mtr, input logic [31:0] d,
                        input logic [31:0] a, input logic [4:0] rd,
                        input logic [4:0] rs, input logic [4:0] rt);
      @(negedge clk);
      reg_write  = we;
      mem_to_reg = mtr;
      data       = d;
      alu_out    = a;
      rd_addr    = rd;
      rs_addr    = rs;
      rt_addr    = rt;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, 1'b0, 32'hBAD0_0001, 32'h0000_0055, 5'd3, 5'd3, 5'd3);
      checks++;
      if (wb_valid !== 1'b0) $display("[TB] FAIL reset_wbvalid got %h required %h", wb_valid, 1'b0);
      else passed++;
      checks++;
      if (wb_data !== 32'h0000_0055) $display("[TB] FAIL reset_wbdata got %h required %h", wb_data, 32'h0000_0055);
      else passed++;
      checks++;
      if (rs_data !== 32'h0) $display("[TB] FAIL reset_bypass_rs got %h required %h", rs_data, 32'h0);
      else passed++;
      tick();
      tick();
      @(negedge clk);
      rst = 1'b0;
      reg_write = 1'b0;
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'(i), 5'(31 - i));
         checks++;
         if (rs_data !== 32'h0) $display("[TB] FAIL reset_read_rs[%0d] got %h required %h", i, rs_data, 32'h0);
         else passed++;
         checks++;
         if (rt_data !== 32'h0) $display("[TB] FAIL reset_read_rt[%0d] got %h required %h", 31 - i, rt_data, 32'h0);
         else passed++;
      end
      checks++;
      if (wb_count !== 32'h0) $display("[TB] FAIL reset_count got %h required %h", wb_count, 32'h0);
      else passed++;
      checks++;
      if (nb_wb_count !== 32'hFFFF_FFFE) $display("[TB] FAIL reset_nb_count got %h required %h", nb_wb_count, 32'hFFFF_FFFE);
      else passed++;
      checks++;
      if (last_valid !== 1'b0) $display("[TB] FAIL reset_lastvalid got %h required %h", last_valid, 1'b0);
      else passed++;
      checks++;
      if (last_addr !== 5'd0 || last_data !== 32'h0)
         $display("[TB] FAIL reset_last got %h/%h required %h/%h", last_addr, last_data, 5'd0, 32'h0);
      else passed++;
   endtask

   task automatic test_wrap();
      drive(1'b1, 1'b0, 32'h0, 32'h0000_0011, 5'd1, 5'd0, 5'd0);
      tick();
      checks++;
      if (nb_wb_count !== 32'hFFFF_FFFF) $display("[TB] FAIL wrap_first got %h required %h", nb_wb_count, 32'hFFFF_FFFF);
      else passed++;
      checks++;
      if (wb_count !== 32'd1) $display("[TB] FAIL count_first got %h required %h", wb_count, 32'd1);
      else passed++;
      drive(1'b1, 1'b0, 32'h0, 32'h0000_0022, 5'd2, 5'd0, 5'd0);
      tick();
      checks++;
      if (nb_wb_count !== 32'h0) $display("[TB] FAIL wrap_second got %h required %h", nb_wb_count, 32'h0);
      else passed++;
      checks++;
      if (wb_count !== 32'd2) $display("[TB] FAIL count_second got %h required %h", wb_count, 32'd2);
      else passed++;
   endtask

   task automatic test_write_all();
      for (int a = 1; a < 32; a++) begin
         drive(1'b1, 1'b0, 32'hBAD0_0000 + 32'(a), 32'hA500_0000 + 32'(a), 5'(a), 5'd0, 5'd0);
         tick();
         checks++;
         if (last_addr !== 5'(a) || last_data !== 32'hA500_0000 + 32'(a) || last_valid !== 1'b1)
            $display("[TB] FAIL write_last[%0d] got %h/%h/%h required %h/%h/1", a, last_addr,
                     last_data, last_valid, 5'(a), 32'hA500_0000 + 32'(a));
         else passed++;
      end
      // RegWrite low with a matching RDaddr must not bypass.
      for (int a = 1; a < 32; a++) begin
         drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 5'(a), 5'(a), 5'(32 - a));
         checks++;
         if (rs_data !== 32'hA500_0000 + 32'(a))
            $display("[TB] FAIL readback_rs[%0d] got %h required %h", a, rs_data, 32'hA500_0000 + 32'(a));
         else passed++;
         checks++;
         if (rt_data !== 32'hA500_0000 + 32'(32 - a))
            $display("[TB] FAIL readback_rt[%0d] got %h required %h", 32 - a, rt_data, 32'hA500_0000 + 32'(32 - a));
         else passed++;
         checks++;
         if (nb_rs_data !== 32'hA500_0000 + 32'(a))
            $display("[TB] FAIL readback_nb_rs[%0d] got %h required %h", a, nb_rs_data, 32'hA500_0000 + 32'(a));
         else passed++;
      end
      tick();
      checks++;
      if (wb_count !== 32'd33) $display("[TB] FAIL count_after_all got %0d required %0d", wb_count, 33);
      else passed++;
      checks++;
      if (nb_wb_count !== 32'd31) $display("[TB] FAIL nb_count_after_all got %0d required %0d", nb_wb_count, 31);
      else passed++;
      checks++;
      if (last_valid !== 1'b0 || last_addr !== 5'd31 || last_data !== 32'hA500_001F)
         $display("[TB] FAIL idle_last got %h/%h/%h required 0/%h/%h", last_valid, last_addr, last_data, 5'd31, 32'hA500_001F);
      else passed++;
   endtask

   task automatic test_bypass();
      drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd7, 5'd7, 5'd7);
      checks++;
      if (rs_data !== 32'hDEAD_BEEF || rt_data !== 32'hDEAD_BEEF)
         $display("[TB] FAIL bypass_ports got %h/%h required %h", rs_data, rt_data, 32'hDEAD_BEEF);
      else passed++;
      checks++;
      if (nb_rs_data !== 32'hA500_0007 || nb_rt_data !== 32'hA500_0007)
         $display("[TB] FAIL nobypass_ports got %h/%h required %h", nb_rs_data, nb_rt_data, 32'hA500_0007);
      else passed++;
      checks++;
      if (wb_valid !== 1'b1 || nb_wb_valid !== 1'b1) $display("[TB] FAIL bypass_wbvalid got %h/%h required 1", wb_valid, nb_wb_valid);
      else passed++;
      checks++;
      if (wb_data !== 32'hDEAD_BEEF || nb_wb_data !== 32'hDEAD_BEEF)
         $display("[TB] FAIL bypass_wbdata got %h/%h required %h", wb_data, nb_wb_data, 32'hDEAD_BEEF);
      else passed++;
      tick();
      checks++;
      if (last_addr !== 5'd7 || last_data !== 32'hDEAD_BEEF || last_valid !== 1'b1)
         $display("[TB] FAIL bypass_last got %h/%h/%h required %h/%h/1", last_addr, last_data, last_valid, 5'd7, 32'hDEAD_BEEF);
      else passed++;
      checks++;
      if (nb_last_addr !== 5'd7 || nb_last_data !== 32'hDEAD_BEEF || nb_last_valid !== 1'b1)
         $display("[TB] FAIL nb_last got %h/%h/%h required %h/%h/1", nb_last_addr, nb_last_data, nb_last_valid, 5'd7, 32'hDEAD_BEEF);
      else passed++;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
      checks++;
      if (nb_rs_data !== 32'hDEAD_BEEF || nb_rt_data !== 32'hDEAD_BEEF)
         $display("[TB] FAIL nobypass_after got %h/%h required %h", nb_rs_data, nb_rt_data, 32'hDEAD_BEEF);
      else passed++;
      checks++;
      if (rs_data !== 32'hDEAD_BEEF) $display("[TB] FAIL bypass_stored got %h required %h", rs_data, 32'hDEAD_BEEF);
      else passed++;
   endtask

   task automatic test_write_zero();
      drive(1'b1, 1'b0, 32'h0, 32'h0000_0099, 5'd9, 5'd0, 5'd0);
      tick();
      drive(1'b1, 1'b0, 32'h0, 32'h1234_5678, 5'd0, 5'd0, 5'd9);
      checks++;
      if (wb_valid !== 1'b0) $display("[TB] FAIL zero_wbvalid got %h required %h", wb_valid, 1'b0);
      else passed++;
      checks++;
      if (wb_data !== 32'h1234_5678) $display("[TB] FAIL zero_wbdata got %h required %h", wb_data, 32'h1234_5678);
      else passed++;
      checks++;
      if (rs_data !== 32'h0 || rt_data !== 32'h0000_0099)
         $display("[TB] FAIL zero_read got %h/%h required %h/%h", rs_data, rt_data, 32'h0, 32'h0000_0099);
      else passed++;
      tick();
      checks++;
      if (last_valid !== 1'b0) $display("[TB] FAIL zero_lastvalid got %h required %h", last_valid, 1'b0);
      else passed++;
      checks++;
      if (last_addr !== 5'd9 || last_data !== 32'h0000_0099)
         $display("[TB] FAIL zero_last_held got %h/%h required %h/%h", last_addr, last_data, 5'd9, 32'h0000_0099);
      else passed++;
      checks++;
      if (wb_count !== 32'd35) $display("[TB] FAIL zero_count got %0d required %0d", wb_count, 35);
      else passed++;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
      checks++;
      if (rs_data !== 32'h0 || nb_rs_data !== 32'h0) $display("[TB] FAIL zero_reg0 got %h/%h required 0", rs_data, nb_rs_data);
      else passed++;
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 1'b0, 32'h0, 32'h0000_0100, 5'd12, 5'd12, 5'd13);
      checks++;
      if (rs_data !== 32'h0000_0100 || rt_data !== 32'hA500_000D)
         $display("[TB] FAIL b2b_first_read got %h/%h required %h/%h", rs_data, rt_data, 32'h100, 32'hA500_000D);
      else passed++;
      checks++;
      if (nb_rs_data !== 32'hA500_000C) $display("[TB] FAIL b2b_first_nb got %h required %h", nb_rs_data, 32'hA500_000C);
      else passed++;
      tick();
      drive(1'b1, 1'b1, 32'h0000_0200, 32'h0, 5'd12, 5'd12, 5'd13);
      checks++;
      if (rs_data !== 32'h0000_0200 || nb_rs_data !== 32'h0000_0100)
         $display("[TB] FAIL b2b_second_read got %h/%h required %h/%h", rs_data, nb_rs_data, 32'h200, 32'h100);
      else passed++;
      tick();
      checks++;
      if (last_valid !== 1'b1 || last_data !== 32'h0000_0200)
         $display("[TB] FAIL b2b_second_last got %h/%h required 1/%h", last_valid, last_data, 32'h200);
      else passed++;
      drive(1'b1, 1'b0, 32'h0, 32'h0000_0300, 5'd12, 5'd12, 5'd12);
      checks++;
      if (rs_data !== 32'h0000_0300 || rt_data !== 32'h0000_0300 || nb_rs_data !== 32'h0000_0200)
         $display("[TB] FAIL b2b_third_read got %h/%h/%h required %h/%h/%h", rs_data, rt_data, nb_rs_data,
                  32'h300, 32'h300, 32'h200);
      else passed++;
      tick();
      checks++;
      if (last_valid !== 1'b1 || last_data !== 32'h0000_0300 || last_addr !== 5'd12)
         $display("[TB] FAIL b2b_third_last got %h/%h/%h required 1/%h/%h", last_valid, last_data, last_addr, 32'h300, 5'd12);
      else passed++;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd12, 5'd12, 5'd12);
      checks++;
      if (rs_data !== 32'h0000_0300 || nb_rs_data !== 32'h0000_0300)
         $display("[TB] FAIL b2b_final got %h/%h required %h", rs_data, nb_rs_data, 32'h300);
      else passed++;
      tick();
      checks++;
      if (last_valid !== 1'b0 || wb_count !== 32'd38)
         $display("[TB] FAIL b2b_idle got %h/%0d required 0/%0d", last_valid, wb_count, 38);
      else passed++;
   endtask

   task automatic test_async_reset();
      drive(1'b1, 1'b0, 32'h0, 32'h0000_CAFE, 5'd20, 5'd20, 5'd9);
      tick();
      checks++;
      if (last_valid !== 1'b1 || last_addr !== 5'd20)
         $display("[TB] FAIL pre_reset_last got %h/%h required 1/%h", last_valid, last_addr, 5'd20);
      else passed++;
      // Assert reset between edges; nothing below waits for a clock edge.
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (rs_data !== 32'h0 || rt_data !== 32'h0) $display("[TB] FAIL async_read got %h/%h required 0", rs_data, rt_data);
      else passed++;
      checks++;
      if (last_valid !== 1'b0 || last_addr !== 5'd0 || last_data !== 32'h0)
         $display("[TB] FAIL async_last got %h/%h/%h required 0/0/0", last_valid, last_addr, last_data);
      else passed++;
      checks++;
      if (wb_count !== 32'h0 || nb_wb_count !== 32'hFFFF_FFFE)
         $display("[TB] FAIL async_count got %h/%h required %h/%h", wb_count, nb_wb_count, 32'h0, 32'hFFFF_FFFE);
      else passed++;
      checks++;
      if (wb_valid !== 1'b0 || wb_data !== 32'h0000_CAFE)
         $display("[TB] FAIL async_wb got %h/%h required 0/%h", wb_valid, wb_data, 32'hCAFE);
      else passed++;
      tick();
      @(negedge clk);
      rst        = 1'b0;
      reg_write  = 1'b1;
      mem_to_reg = 1'b0;
      alu_out    = 32'h0000_5555;
      rd_addr    = 5'd5;
      rs_addr    = 5'd20;
      rt_addr    = 5'd9;
      #1;
      checks++;
      if (rs_data !== 32'h0 || rt_data !== 32'h0 || nb_rs_data !== 32'h0)
         $display("[TB] FAIL post_reset_storage got %h/%h/%h required 0", rs_data, rt_data, nb_rs_data);
      else passed++;
      tick();
      checks++;
      if (wb_count !== 32'd1 || last_valid !== 1'b1 || last_data !== 32'h0000_5555)
         $display("[TB] FAIL first_write_after_reset got %0d/%h/%h required 1/1/%h", wb_count, last_valid, last_data, 32'h5555);
      else passed++;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
      checks++;
      if (rs_data !== 32'h0000_5555 || nb_rt_data !== 32'h0000_5555)
         $display("[TB] FAIL first_write_readback got %h/%h required %h", rs_data, nb_rt_data, 32'h5555);
      else passed++;
   endtask

   initial begin
      rst        = 1'b1;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      data       = 32'h0;
      alu_out    = 32'h0;
      rd_addr    = 5'd0;
      rs_addr    = 5'd0;
      rt_addr    = 5'd0;
      test_reset();
      test_wrap();
      test_write_all();
      test_bypass();
      test_write_zero();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
